// File: rtl/commit_trace_unit_pkg.sv
// Shared constants and types for the commit-trace front end.
// The FSM encodings are plain localparams so older tools read them directly.
package commit_trace_unit_pkg;

    localparam int          COMMIT_WIDTH_DEF = 2;
    localparam int          DATA_W_DEF       = 32;
    localparam int          REG_ADDR_W_DEF   = 5;
    localparam logic [31:0] HALT_INSTR_DEF   = 32'h8000_0000;
    localparam logic [15:0] TIMEOUT_CYC_DEF  = 16'd5000;
    localparam int          SLOT_IDX_W       = 8;
    localparam int          PERF_CNT_W       = 64;

    localparam logic [1:0]  ST_RUN        = 2'd0;
    localparam logic [1:0]  ST_TRAP_PULSE = 2'd1;
    localparam logic [1:0]  ST_HALTED     = 2'd2;

    typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

endpackage

// File: rtl/commit_trace_unit_if.sv
// Bundle between cpu_top commit channels and the difftest commit/trap sinks.
interface commit_trace_unit_if
    import commit_trace_unit_pkg::*;
#(
    parameter int CW         = COMMIT_WIDTH_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

    logic                         perf_clean_i;
    logic [CW-1:0]                cmt_valid_i;
    logic [CW*DATA_W-1:0]         cmt_pc_i;
    logic [CW*DATA_W-1:0]         cmt_instr_i;
    logic [CW-1:0]                cmt_wen_i;
    logic [CW*REG_ADDR_W-1:0]     cmt_waddr_i;
    logic [CW*DATA_W-1:0]         cmt_wdata_i;
    logic [DATA_W-1:0]            a0_i;

    logic [CW-1:0]                dt_valid_o;
    logic [CW*SLOT_IDX_W-1:0]     dt_index_o;
    logic [CW*DATA_W-1:0]         dt_pc_o;
    logic [CW*DATA_W-1:0]         dt_instr_o;
    logic [CW-1:0]                dt_wen_o;
    logic [CW*REG_ADDR_W-1:0]     dt_wdest_o;
    logic [CW*DATA_W-1:0]         dt_wdata_o;
    perf_cnt_t                    cycle_cnt_o;
    perf_cnt_t                    instr_cnt_o;
    logic                         trap_valid_o;
    logic [7:0]                   trap_code_o;
    logic [DATA_W-1:0]            trap_pc_o;
    logic                         halted_o;
    logic                         timeout_o;

    modport master (
        output perf_clean_i, cmt_valid_i, cmt_pc_i, cmt_instr_i, cmt_wen_i,
               cmt_waddr_i, cmt_wdata_i, a0_i,
        input  dt_valid_o, dt_index_o, dt_pc_o, dt_instr_o, dt_wen_o, dt_wdest_o,
               dt_wdata_o, cycle_cnt_o, instr_cnt_o, trap_valid_o, trap_code_o,
               trap_pc_o, halted_o, timeout_o
    );

    modport slave (
        input  perf_clean_i, cmt_valid_i, cmt_pc_i, cmt_instr_i, cmt_wen_i,
               cmt_waddr_i, cmt_wdata_i, a0_i,
        output dt_valid_o, dt_index_o, dt_pc_o, dt_instr_o, dt_wen_o, dt_wdest_o,
               dt_wdata_o, cycle_cnt_o, instr_cnt_o, trap_valid_o, trap_code_o,
               trap_pc_o, halted_o, timeout_o
    );

endinterface

// File: rtl/commit_trace_unit_compactor.sv
// Combinational slot selection: accepts valid channels up to and including the
// first halt instruction, then packs them into the lowest slots in channel order.
module commit_trace_unit_compactor
    import commit_trace_unit_pkg::*;
#(
    parameter int                CW         = COMMIT_WIDTH_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                REG_ADDR_W = REG_ADDR_W_DEF,
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_INSTR_DEF)
) (
    input  logic [CW-1:0]            valid,
    input  logic [CW*DATA_W-1:0]     pc,
    input  logic [CW*DATA_W-1:0]     instr,
    input  logic [CW-1:0]            wen,
    input  logic [CW*REG_ADDR_W-1:0] waddr,
    input  logic [CW*DATA_W-1:0]     wdata,
    output logic [CW-1:0]            slot_valid,
    output logic [CW*DATA_W-1:0]     slot_pc,
    output logic [CW*DATA_W-1:0]     slot_instr,
    output logic [CW-1:0]            slot_wen,
    output logic [CW*REG_ADDR_W-1:0] slot_wdest,
    output logic [CW*DATA_W-1:0]     slot_wdata,
    output logic [7:0]               accept_cnt,
    output logic                     halt_hit,
    output logic [DATA_W-1:0]        halt_pc
);

    logic [CW-1:0] accept;

    // Once a halt is seen, every younger channel in the same cycle is dropped.
    always_comb begin
        accept     = '0;
        accept_cnt = 8'd0;
        halt_hit   = 1'b0;
        halt_pc    = '0;
        for (int i = 0; i < CW; i++) begin
            if (valid[i] && !halt_hit) begin
                accept[i]  = 1'b1;
                accept_cnt = accept_cnt + 8'd1;
                if (instr[i*DATA_W +: DATA_W] == HALT_INSTR) begin
                    halt_hit = 1'b1;
                    halt_pc  = pc[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar gi = 0; gi < CW; gi++) begin : g_slot
        logic                  sel_valid;
        logic                  sel_wen;
        logic [DATA_W-1:0]     sel_pc;
        logic [DATA_W-1:0]     sel_instr;
        logic [DATA_W-1:0]     sel_wdata;
        logic [REG_ADDR_W-1:0] sel_wdest;

        // Slot gi takes the accepted channel whose count of older accepted channels is gi.
        always_comb begin
            logic [7:0] rank;
            rank      = 8'd0;
            sel_valid = 1'b0;
            sel_wen   = 1'b0;
            sel_pc    = '0;
            sel_instr = '0;
            sel_wdata = '0;
            sel_wdest = '0;
            for (int i = 0; i < CW; i++) begin
                if (accept[i]) begin
                    if (rank == 8'(gi)) begin
                        sel_valid = 1'b1;
                        sel_wen   = wen[i];
                        sel_pc    = pc[i*DATA_W +: DATA_W];
                        sel_instr = instr[i*DATA_W +: DATA_W];
                        sel_wdata = wdata[i*DATA_W +: DATA_W];
                        sel_wdest = waddr[i*REG_ADDR_W +: REG_ADDR_W];
                    end
                    rank = rank + 8'd1;
                end
            end
        end

        assign slot_valid[gi]                          = sel_valid;
        assign slot_wen[gi]                            = sel_wen;
        assign slot_pc[gi*DATA_W +: DATA_W]            = sel_pc;
        assign slot_instr[gi*DATA_W +: DATA_W]         = sel_instr;
        assign slot_wdata[gi*DATA_W +: DATA_W]         = sel_wdata;
        assign slot_wdest[gi*REG_ADDR_W +: REG_ADDR_W] = sel_wdest;
    end

endmodule

// File: rtl/commit_trace_unit.sv
// Commit-trace front end: registered compacted commit slots, perf counters,
// halt/trap sequencing and a commit-starvation watchdog.
module commit_trace_unit
    import commit_trace_unit_pkg::*;
#(
    parameter int                COMMIT_WIDTH = COMMIT_WIDTH_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter int                REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter logic [DATA_W-1:0] HALT_INSTR   = DATA_W'(HALT_INSTR_DEF),
    parameter logic [15:0]       TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
    input logic               clock,
    input logic               reset_n,
    commit_trace_unit_if.slave trace
);

    localparam int CW = COMMIT_WIDTH;

    logic [1:0]                state_reg, state_next;
    logic [CW-1:0]             dt_valid_reg;
    logic [CW*SLOT_IDX_W-1:0]  dt_index_reg;
    logic [CW*DATA_W-1:0]      dt_pc_reg, dt_instr_reg, dt_wdata_reg;
    logic [CW-1:0]             dt_wen_reg;
    logic [CW*REG_ADDR_W-1:0]  dt_wdest_reg;
    perf_cnt_t                 cycle_cnt_reg, instr_cnt_reg;
    logic [15:0]               idle_cnt_reg, idle_cnt_next;
    logic                      timeout_reg, timeout_next;
    logic [7:0]                trap_code_reg;
    logic [DATA_W-1:0]         trap_pc_reg;

    logic                      running;
    logic                      wd_active;
    logic [CW-1:0]             valid_gated;
    logic [CW-1:0]             slot_valid, slot_wen;
    logic [CW*DATA_W-1:0]      slot_pc, slot_instr, slot_wdata;
    logic [CW*REG_ADDR_W-1:0]  slot_wdest;
    logic [CW*SLOT_IDX_W-1:0]  slot_index;
    logic [7:0]                accept_cnt;
    logic                      halt_hit;
    logic [DATA_W-1:0]         halt_pc;

    assign running     = (state_reg == ST_RUN);
    assign valid_gated = running ? trace.cmt_valid_i : '0;

    commit_trace_unit_compactor #(
        .CW(CW), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .HALT_INSTR(HALT_INSTR)
    ) u_compactor (
        .valid      (valid_gated),
        .pc         (trace.cmt_pc_i),
        .instr      (trace.cmt_instr_i),
        .wen        (trace.cmt_wen_i),
        .waddr      (trace.cmt_waddr_i),
        .wdata      (trace.cmt_wdata_i),
        .slot_valid (slot_valid),
        .slot_pc    (slot_pc),
        .slot_instr (slot_instr),
        .slot_wen   (slot_wen),
        .slot_wdest (slot_wdest),
        .slot_wdata (slot_wdata),
        .accept_cnt (accept_cnt),
        .halt_hit   (halt_hit),
        .halt_pc    (halt_pc)
    );

    for (genvar gi = 0; gi < CW; gi++) begin : g_index
        assign slot_index[gi*SLOT_IDX_W +: SLOT_IDX_W] =
            slot_valid[gi] ? SLOT_IDX_W'(gi) : '0;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:        if (halt_hit) state_next = ST_TRAP_PULSE;
            ST_TRAP_PULSE: state_next = ST_HALTED;
            ST_HALTED:     state_next = ST_HALTED;
            default:       state_next = ST_RUN;
        endcase
    end

    // Idle counter saturates so a very long stall cannot wrap back under the threshold.
    always_comb begin
        wd_active     = running && (TIMEOUT_CYC != 16'd0);
        idle_cnt_next = idle_cnt_reg;
        if (wd_active) begin
            if ((accept_cnt != 8'd0) || trace.perf_clean_i)
                idle_cnt_next = 16'd0;
            else if (idle_cnt_reg != 16'hFFFF)
                idle_cnt_next = idle_cnt_reg + 16'd1;
        end
        timeout_next = timeout_reg | (wd_active && (idle_cnt_next >= TIMEOUT_CYC));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_RUN;
            dt_valid_reg  <= '0;
            dt_index_reg  <= '0;
            dt_pc_reg     <= '0;
            dt_instr_reg  <= '0;
            dt_wen_reg    <= '0;
            dt_wdest_reg  <= '0;
            dt_wdata_reg  <= '0;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
            trap_code_reg <= '0;
            trap_pc_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            dt_valid_reg <= slot_valid;
            dt_index_reg <= slot_index;
            dt_pc_reg    <= slot_pc;
            dt_instr_reg <= slot_instr;
            dt_wen_reg   <= slot_wen;
            dt_wdest_reg <= slot_wdest;
            dt_wdata_reg <= slot_wdata;
            idle_cnt_reg <= idle_cnt_next;
            timeout_reg  <= timeout_next;
            if (halt_hit) begin
                trap_code_reg <= trace.a0_i[7:0];
                trap_pc_reg   <= halt_pc;
            end
            if (trace.perf_clean_i) begin
                cycle_cnt_reg <= '0;
                instr_cnt_reg <= '0;
            end else begin
                cycle_cnt_reg <= cycle_cnt_reg + perf_cnt_t'(1);
                instr_cnt_reg <= instr_cnt_reg + perf_cnt_t'(accept_cnt);
            end
        end
    end

    assign trace.dt_valid_o   = dt_valid_reg;
    assign trace.dt_index_o   = dt_index_reg;
    assign trace.dt_pc_o      = dt_pc_reg;
    assign trace.dt_instr_o   = dt_instr_reg;
    assign trace.dt_wen_o     = dt_wen_reg;
    assign trace.dt_wdest_o   = dt_wdest_reg;
    assign trace.dt_wdata_o   = dt_wdata_reg;
    assign trace.cycle_cnt_o  = cycle_cnt_reg;
    assign trace.instr_cnt_o  = instr_cnt_reg;
    assign trace.trap_valid_o = (state_reg == ST_TRAP_PULSE);
    assign trace.trap_code_o  = trap_code_reg;
    assign trace.trap_pc_o    = trap_pc_reg;
    assign trace.halted_o     = !running;
    assign trace.timeout_o    = timeout_reg;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Scoreboard bench for commit_trace_unit: expected slots are queued at drive time
// and popped one cycle later; counters/trap/watchdog follow a small reference model.
module tb_commit_trace_unit;
    import commit_trace_unit_pkg::*;

    localparam int          CW   = 2;
    localparam int          DW   = 32;
    localparam int          AW   = 5;
    localparam logic [31:0] HALT = 32'h8000_0000;
    localparam logic [15:0] TO   = 16'd8;
    localparam int          DT_W = CW + CW*8 + 3*CW*DW + CW + CW*AW;
    localparam int          ST_W = 64 + 64 + 1 + 8 + DW + 1 + 1;

    typedef struct {
        logic [CW-1:0]          valid;
        logic [CW-1:0][DW-1:0]  pc;
        logic [CW-1:0][DW-1:0]  instr;
        logic [CW-1:0][DW-1:0]  wdata;
        logic [CW-1:0]          wen;
        logic [CW-1:0][AW-1:0]  waddr;
        logic [DW-1:0]          a0;
        logic                   clean;
    } stim_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    commit_trace_unit_if #(.CW(CW), .DATA_W(DW), .REG_ADDR_W(AW)) bus ();

    commit_trace_unit #(
        .COMMIT_WIDTH(CW), .DATA_W(DW), .REG_ADDR_W(AW), .HALT_INSTR(HALT), .TIMEOUT_CYC(TO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .trace   (bus)
    );

    logic [DT_W-1:0] dt_obs, exp_dt;
    logic [ST_W-1:0] st_obs, st_exp;
    assign dt_obs = {bus.dt_valid_o, bus.dt_index_o, bus.dt_pc_o, bus.dt_instr_o,
                     bus.dt_wen_o, bus.dt_wdest_o, bus.dt_wdata_o};
    assign st_obs = {bus.cycle_cnt_o, bus.instr_cnt_o, bus.trap_valid_o, bus.trap_code_o,
                     bus.trap_pc_o, bus.halted_o, bus.timeout_o};

    logic [DT_W-1:0] exp_q[$];
    logic [63:0]     m_cycle, m_instr;
    logic            m_trap_valid, m_halted, m_timeout;
    logic [7:0]      m_trap_code;
    logic [DW-1:0]   m_trap_pc;
    int              m_idle;
    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_txn = 0;

    assign st_exp = {m_cycle, m_instr, m_trap_valid, m_trap_code, m_trap_pc, m_halted, m_timeout};

    function automatic stim_t rand_stim(input logic [CW-1:0] valid);
        stim_t s;
        s.valid = valid;
        s.clean = 1'b0;
        s.a0    = $urandom;
        s.wen   = CW'($urandom);
        for (int i = 0; i < CW; i++) begin
            s.pc[i]    = $urandom;
            s.instr[i] = {1'b0, 31'($urandom)};
            s.wdata[i] = $urandom;
            s.waddr[i] = AW'($urandom);
        end
        return s;
    endfunction

    task automatic reset_model();
        m_cycle = '0; m_instr = '0; m_trap_valid = 1'b0; m_halted = 1'b0;
        m_timeout = 1'b0; m_trap_code = '0; m_trap_pc = '0; m_idle = 0;
        exp_q.delete();
    endtask

    task automatic drive_inputs(input stim_t s);
        bus.perf_clean_i = s.clean;
        bus.cmt_valid_i  = s.valid;
        bus.cmt_pc_i     = s.pc;
        bus.cmt_instr_i  = s.instr;
        bus.cmt_wen_i    = s.wen;
        bus.cmt_waddr_i  = s.waddr;
        bus.cmt_wdata_i  = s.wdata;
        bus.a0_i         = s.a0;
    endtask

    // Drive one cycle of stimulus, push the expected slots, advance, pop.
    task automatic step(input stim_t s);
        logic [CW-1:0]          ev, ew;
        logic [CW-1:0][7:0]     ei;
        logic [CW-1:0][DW-1:0]  ep, ein, ed;
        logic [CW-1:0][AW-1:0]  ea;
        logic                   hit, was_halted;
        int                     k;
        drive_inputs(s);
        ev = '0; ew = '0; ei = '0; ep = '0; ein = '0; ed = '0; ea = '0;
        hit = 1'b0; k = 0; was_halted = m_halted;
        if (!was_halted) begin
            for (int i = 0; i < CW; i++) begin
                if (s.valid[i] && !hit) begin
                    ev[k] = 1'b1; ei[k] = 8'(k); ep[k] = s.pc[i]; ein[k] = s.instr[i];
                    ew[k] = s.wen[i]; ea[k] = s.waddr[i]; ed[k] = s.wdata[i];
                    if (s.instr[i] == HALT) begin
                        hit = 1'b1; m_trap_pc = s.pc[i]; m_trap_code = s.a0[7:0];
                    end
                    k++;
                end
            end
        end
        exp_q.push_back({ev, ei, ep, ein, ew, ea, ed});
        m_trap_valid = hit;
        if (hit) m_halted = 1'b1;
        if (s.clean) begin
            m_cycle = '0; m_instr = '0;
        end else begin
            m_cycle = m_cycle + 64'd1; m_instr = m_instr + 64'(k);
        end
        if (!was_halted) begin
            if (k > 0 || s.clean) m_idle = 0;
            else if (m_idle < 65535) m_idle++;
            if (m_idle >= int'(TO)) m_timeout = 1'b1;
        end
        @(posedge clock); #1;
        exp_dt = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: valid=%b clean=%b -> dt_valid=%b cycle=%0d instr=%0d trap=%b halted=%b timeout=%b",
                 n_txn, s.valid, s.clean, bus.dt_valid_o, bus.cycle_cnt_o, bus.instr_cnt_o,
                 bus.trap_valid_o, bus.halted_o, bus.timeout_o);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        reset_model();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        reset_model();
        for (int c = 0; c < 3; c++) begin
            drive_inputs(rand_stim(2'b11));
            @(posedge clock); #1;
            n_cmp++;
            if (dt_obs !== '0) begin n_bad++; $display("FAIL reset_dt got=%h want=0", dt_obs); end
            n_cmp++;
            if (st_obs !== '0) begin n_bad++; $display("FAIL reset_status got=%h want=0", st_obs); end
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(rand_stim(2'b00));
            n_cmp++;
            if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL idle_dt got=%h want=%h", dt_obs, exp_dt); end
        end
        n_cmp++;
        if ({bus.cycle_cnt_o, bus.instr_cnt_o} !== {64'd3, 64'd0}) begin
            n_bad++;
            $display("FAIL idle_counters got cycle=%0d instr=%0d want cycle=3 instr=0", bus.cycle_cnt_o, bus.instr_cnt_o);
        end
    endtask

    task automatic test_compaction();
        stim_t s;
        logic [CW-1:0] pats [6] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};
        s = rand_stim(2'b10);
        s.pc[1] = 32'h1c00_0004;
        step(s);
        n_cmp++;
        if ({bus.dt_valid_o, bus.dt_pc_o[31:0], bus.dt_index_o[7:0], bus.instr_cnt_o} !==
            {2'b01, 32'h1c00_0004, 8'h00, 64'd1}) begin
            n_bad++;
            $display("FAIL compact_ch1 got valid=%b pc0=%h idx0=%0d instr=%0d want valid=01 pc0=1c000004 idx0=0 instr=1",
                     bus.dt_valid_o, bus.dt_pc_o[31:0], bus.dt_index_o[7:0], bus.instr_cnt_o);
        end
        n_cmp++;
        if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL compact_ch1_dt got=%h want=%h", dt_obs, exp_dt); end
        foreach (pats[p]) begin
            step(rand_stim(pats[p]));
            n_cmp++;
            if (dt_obs !== exp_dt) begin
                n_bad++; $display("FAIL compact_%b_dt got=%h want=%h", pats[p], dt_obs, exp_dt);
            end
            n_cmp++;
            if (st_obs !== st_exp) begin
                n_bad++; $display("FAIL compact_%b_status got=%h want=%h", pats[p], st_obs, st_exp);
            end
        end
    endtask

    task automatic test_perf_clean();
        stim_t s;
        s = rand_stim(2'b11);
        s.clean = 1'b1;
        step(s);
        n_cmp++;
        if ({bus.dt_valid_o, bus.cycle_cnt_o, bus.instr_cnt_o} !== {2'b11, 64'd0, 64'd0}) begin
            n_bad++;
            $display("FAIL perf_clean got valid=%b cycle=%0d instr=%0d want valid=11 cycle=0 instr=0",
                     bus.dt_valid_o, bus.cycle_cnt_o, bus.instr_cnt_o);
        end
        n_cmp++;
        if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL perf_clean_dt got=%h want=%h", dt_obs, exp_dt); end
        step(rand_stim(2'b00));
        n_cmp++;
        if (st_obs !== st_exp) begin n_bad++; $display("FAIL after_clean_status got=%h want=%h", st_obs, st_exp); end
    endtask

    task automatic test_timeout();
        step(rand_stim(2'b01));
        for (int c = 1; c <= 8; c++) begin
            step(rand_stim(2'b00));
            n_cmp++;
            if (st_obs !== st_exp) begin n_bad++; $display("FAIL watchdog_%0d_status got=%h want=%h", c, st_obs, st_exp); end
            if (c == 7) begin
                n_cmp++;
                if (bus.timeout_o !== 1'b0) begin n_bad++; $display("FAIL timeout_early got=%b want=0", bus.timeout_o); end
            end
        end
        n_cmp++;
        if (bus.timeout_o !== 1'b1) begin n_bad++; $display("FAIL timeout_set got=%b want=1", bus.timeout_o); end
        step(rand_stim(2'b11));
        n_cmp++;
        if ({bus.timeout_o, bus.dt_valid_o} !== {1'b1, 2'b11}) begin
            n_bad++; $display("FAIL timeout_sticky got timeout=%b valid=%b want 1/11", bus.timeout_o, bus.dt_valid_o);
        end
    endtask

    task automatic test_trap();
        stim_t s;
        s = rand_stim(2'b11);
        s.instr[0] = HALT;
        s.a0 = 32'h1234_5600;
        step(s);
        n_cmp++;
        if ({bus.dt_valid_o, bus.trap_valid_o, bus.trap_code_o, bus.halted_o, bus.trap_pc_o} !==
            {2'b01, 1'b1, 8'h00, 1'b1, s.pc[0]}) begin
            n_bad++;
            $display("FAIL trap_ch0 got valid=%b trap=%b code=%h halted=%b pc=%h want 01/1/00/1/%h",
                     bus.dt_valid_o, bus.trap_valid_o, bus.trap_code_o, bus.halted_o, bus.trap_pc_o, s.pc[0]);
        end
        n_cmp++;
        if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL trap_ch0_dt got=%h want=%h", dt_obs, exp_dt); end
        for (int c = 0; c < 3; c++) begin
            step(rand_stim(2'b11));
            n_cmp++;
            if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL halted_%0d_dt got=%h want=%h", c, dt_obs, exp_dt); end
            n_cmp++;
            if (st_obs !== st_exp) begin n_bad++; $display("FAIL halted_%0d_status got=%h want=%h", c, st_obs, st_exp); end
        end
    endtask

    task automatic test_trap_ch1();
        stim_t s;
        apply_reset();
        s = rand_stim(2'b11);
        s.instr[1] = HALT;
        s.a0 = 32'hABCD_EF05;
        step(s);
        n_cmp++;
        if ({bus.dt_valid_o, bus.trap_code_o, bus.trap_pc_o} !== {2'b11, 8'h05, s.pc[1]}) begin
            n_bad++;
            $display("FAIL trap_ch1 got valid=%b code=%h pc=%h want 11/05/%h",
                     bus.dt_valid_o, bus.trap_code_o, bus.trap_pc_o, s.pc[1]);
        end
        n_cmp++;
        if (st_obs !== st_exp) begin n_bad++; $display("FAIL trap_ch1_status got=%h want=%h", st_obs, st_exp); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(rand_stim(2'b11));
        step(rand_stim(2'b11));
        n_cmp++;
        if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL pre_reset_dt got=%h want=%h", dt_obs, exp_dt); end
        #2;
        reset_n = 1'b0;
        reset_model();
        #1;
        n_cmp++;
        if ({bus.dt_valid_o, bus.cycle_cnt_o, bus.instr_cnt_o} !== '0) begin
            n_bad++;
            $display("FAIL async_reset got valid=%b cycle=%0d instr=%0d want all 0",
                     bus.dt_valid_o, bus.cycle_cnt_o, bus.instr_cnt_o);
        end
        @(posedge clock); #1;
        n_cmp++;
        if ({dt_obs, st_obs} !== '0) begin n_bad++; $display("FAIL reset_hold got=%h want=0", {dt_obs, st_obs}); end
        reset_n = 1'b1;
        step(rand_stim(2'b11));
        n_cmp++;
        if (dt_obs !== exp_dt) begin n_bad++; $display("FAIL post_reset_dt got=%h want=%h", dt_obs, exp_dt); end
        n_cmp++;
        if (st_obs !== st_exp) begin n_bad++; $display("FAIL post_reset_status got=%h want=%h", st_obs, st_exp); end
    endtask

    initial begin
        drive_inputs(rand_stim(2'b00));
        #1;
        test_reset();
        test_compaction();
        test_perf_clean();
        test_timeout();
        test_trap();
        test_trap_ch1();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached without finishing");
        $fatal(1, "time limit");
    end

endmodule
